// File: rtl/muu_resp_packetizer512_if.sv
// Handshake bundle for the response packetizer.
// Input side: {meta, word} stream from the value-get stage.
// Output side: TX metadata beat followed by payload beats.
// "slave" is the packetizer's view; "master" is the surrounding logic's view.
interface muu_resp_packetizer512_if #(
  parameter int META_WIDTH = 96
);
  // Upstream response words
  logic [META_WIDTH+511:0] in_data;
  logic [7:0]              in_user;
  logic                    in_valid;
  logic                    in_last;
  logic                    in_ready;

  // TX metadata beat: {user[55:48], length_bytes[47:16], session[15:0]}
  logic [55:0]             tx_meta_data;
  logic                    tx_meta_valid;
  logic                    tx_meta_ready;

  // TX payload
  logic [511:0]            tx_data;
  logic [63:0]             tx_keep;
  logic                    tx_valid;
  logic                    tx_last;
  logic                    tx_ready;

  modport slave (
    input  in_data, in_user, in_valid, in_last, tx_meta_ready, tx_ready,
    output in_ready, tx_meta_data, tx_meta_valid, tx_data, tx_keep, tx_valid, tx_last
  );

  modport master (
    output in_data, in_user, in_valid, in_last, tx_meta_ready, tx_ready,
    input  in_ready, tx_meta_data, tx_meta_valid, tx_data, tx_keep, tx_valid, tx_last
  );
endinterface

// File: rtl/muu_resp_packetizer512.sv
// Store-and-forward response packetizer.
// Payload words are written into a ring buffer. Every closed packet pushes a
// {user, length, session} record into a small length queue. A read FSM then
// emits one metadata beat per record, followed by that packet's words in
// order. Responses that reach MAX_WORDS_IN_PACKET without in_last are
// force-closed, and each forced close is counted.
module muu_resp_packetizer512 #(
  parameter int META_WIDTH          = 96,
  parameter int SESSION_LSB         = 0,
  parameter int MAX_WORDS_IN_PACKET = 160,  // must be <= BUF_WORDS
  parameter int BUF_WORDS           = 256,  // power of two
  parameter int LENQ_DEPTH          = 4     // power of two, >= 2
) (
  input  logic                            clk,
  input  logic                            rst,
  muu_resp_packetizer512_if.slave         bus,
  output logic [15:0]                     trunc_count
);

  localparam int AW = $clog2(BUF_WORDS);
  localparam int UW = AW + 1;
  localparam int QW = $clog2(LENQ_DEPTH);

  localparam logic [AW-1:0] AW_ONE   = AW'(1);
  localparam logic [UW-1:0] UW_ONE   = UW'(1);
  localparam logic [UW-1:0] BUF_FULL = UW'(BUF_WORDS);
  localparam logic [QW-1:0] QW_ONE   = QW'(1);
  localparam logic [QW:0]   Q_ONE    = (QW+1)'(1);
  localparam logic [QW:0]   LQ_FULL  = (QW+1)'(LENQ_DEPTH);
  localparam logic [9:0]    MAX_W    = 10'(MAX_WORDS_IN_PACKET);

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_META,
    RD_DATA
  } rd_state_e;

  // Storage
  logic [511:0] buf_mem  [BUF_WORDS];
  logic [55:0]  lenq_mem [LENQ_DEPTH];

  // Write-side state
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [UW-1:0] used_q, used_d;
  logic [9:0]    wcnt_q, wcnt_d, wcnt_inc;
  logic [15:0]   session_q, session_d, cur_session, in_session;
  logic [7:0]    user_q, user_d, cur_user;
  logic [15:0]   trunc_q, trunc_d;
  logic [QW-1:0] lq_wr_q, lq_wr_d, lq_rd_q, lq_rd_d;
  logic [QW:0]   lq_cnt_q, lq_cnt_d;

  // Read-side state
  rd_state_e     rd_state_q;
  logic [AW-1:0] rd_ptr_q;
  logic [9:0]    rd_left_q;
  logic [55:0]   tx_meta_data_q;
  logic          tx_meta_valid_q;
  logic          tx_valid_q;
  logic          tx_last_q;
  logic [511:0]  tx_data_q;

  // Handshake / control
  logic          in_ready;
  logic          wr_fire, tx_fire, last_fire;
  logic          close_now, force_close;
  logic          lq_push, lq_pop;
  logic [55:0]   lenq_head;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  assign in_session = bus.in_data[512+SESSION_LSB +: 16];
  assign lenq_head  = lenq_mem[lq_rd_q];

  // Handshakes and packet-close decisions for the current cycle
  always_comb begin
    in_ready    = !rst && (used_q < BUF_FULL) && (lq_cnt_q < LQ_FULL);
    wr_fire     = bus.in_valid && in_ready;
    tx_fire     = tx_valid_q && bus.tx_ready;
    last_fire   = tx_fire && (rd_left_q == 10'd1);
    wcnt_inc    = wcnt_q + 10'd1;
    // A one-word packet closes on its first word, so the record must take meta
    // straight from the bus rather than from the latch.
    cur_session = (wcnt_q == 10'd0) ? in_session  : session_q;
    cur_user    = (wcnt_q == 10'd0) ? bus.in_user : user_q;
    force_close = wr_fire && !bus.in_last && (wcnt_inc == MAX_W);
    close_now   = wr_fire && (bus.in_last || (wcnt_inc == MAX_W));
    lq_push     = close_now;
    // The FSM takes a record either when idle, or straight from the final
    // payload handshake so back-to-back packets need no idle cycle.
    lq_pop      = (lq_cnt_q != '0) &&
                  ((rd_state_q == RD_IDLE) || ((rd_state_q == RD_DATA) && last_fire));
  end

  // Next-state values for write pointer, counters and the length queue
  always_comb begin
    wr_ptr_d  = wr_fire ? (wr_ptr_q + AW_ONE) : wr_ptr_q;
    wcnt_d    = close_now ? 10'd0 : (wr_fire ? wcnt_inc : wcnt_q);
    session_d = wr_fire ? cur_session : session_q;
    user_d    = wr_fire ? cur_user : user_q;
    trunc_d   = (force_close && (trunc_q != 16'hFFFF)) ? (trunc_q + 16'd1) : trunc_q;

    used_d = used_q;
    case ({wr_fire, tx_fire})
      2'b10:   used_d = used_q + UW_ONE;
      2'b01:   used_d = used_q - UW_ONE;
      default: used_d = used_q;
    endcase

    lq_wr_d = lq_push ? (lq_wr_q + QW_ONE) : lq_wr_q;
    lq_rd_d = lq_pop  ? (lq_rd_q + QW_ONE) : lq_rd_q;
    lq_cnt_d = lq_cnt_q;
    case ({lq_push, lq_pop})
      2'b10:   lq_cnt_d = lq_cnt_q + Q_ONE;
      2'b01:   lq_cnt_d = lq_cnt_q - Q_ONE;
      default: lq_cnt_d = lq_cnt_q;
    endcase
  end

  // Write-side registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      used_q    <= '0;
      wcnt_q    <= '0;
      session_q <= '0;
      user_q    <= '0;
      trunc_q   <= '0;
      lq_wr_q   <= '0;
      lq_rd_q   <= '0;
      lq_cnt_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      used_q    <= used_d;
      wcnt_q    <= wcnt_d;
      session_q <= session_d;
      user_q    <= user_d;
      trunc_q   <= trunc_d;
      lq_wr_q   <= lq_wr_d;
      lq_rd_q   <= lq_rd_d;
      lq_cnt_q  <= lq_cnt_d;
    end
  end

  // Payload ring write port
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      buf_mem[wr_ptr_q] <= bus.in_data[511:0];
    end
  end

  // Length queue write port; byte length = words * 64
  always_ff @(posedge clk) begin
    if (lq_push) begin
      lenq_mem[lq_wr_q] <= {cur_user, {16'd0, wcnt_inc, 6'd0}, cur_session};
    end
  end

  // Ring read address: the first word after the meta handshake, then the next
  // word on every payload handshake that is not the last.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = rd_ptr_q;
    if ((rd_state_q == RD_META) && tx_meta_valid_q && bus.tx_meta_ready) begin
      rd_en = 1'b1;
    end else if ((rd_state_q == RD_DATA) && tx_fire && (rd_left_q != 10'd1)) begin
      rd_en   = 1'b1;
      rd_addr = rd_ptr_q + AW_ONE;
    end
  end

  // Registered ring read; this register is the tx_data output and holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q <= '0;
    end else if (rd_en) begin
      tx_data_q <= buf_mem[rd_addr];
    end
  end

  // Read FSM: pop a record, present meta, then stream that many words
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q      <= RD_IDLE;
      rd_ptr_q        <= '0;
      rd_left_q       <= '0;
      tx_meta_data_q  <= '0;
      tx_meta_valid_q <= 1'b0;
      tx_valid_q      <= 1'b0;
      tx_last_q       <= 1'b0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (lq_pop) begin
            tx_meta_data_q  <= lenq_head;
            tx_meta_valid_q <= 1'b1;
            rd_left_q       <= lenq_head[31:22];
            rd_state_q      <= RD_META;
          end
        end
        RD_META: begin
          if (bus.tx_meta_ready) begin
            tx_meta_valid_q <= 1'b0;
            tx_valid_q      <= 1'b1;
            tx_last_q       <= (rd_left_q == 10'd1);
            rd_state_q      <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (tx_fire) begin
            rd_ptr_q  <= rd_ptr_q + AW_ONE;
            rd_left_q <= rd_left_q - 10'd1;
            if (rd_left_q == 10'd1) begin
              tx_valid_q <= 1'b0;
              tx_last_q  <= 1'b0;
              if (lq_pop) begin
                tx_meta_data_q  <= lenq_head;
                tx_meta_valid_q <= 1'b1;
                rd_left_q       <= lenq_head[31:22];
                rd_state_q      <= RD_META;
              end else begin
                rd_state_q <= RD_IDLE;
              end
            end else begin
              tx_last_q <= (rd_left_q == 10'd2);
            end
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.tx_meta_data  = tx_meta_data_q;
  assign bus.tx_meta_valid = tx_meta_valid_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_keep       = {64{1'b1}};
  assign bus.tx_valid      = tx_valid_q;
  assign bus.tx_last       = tx_last_q;
  assign trunc_count       = trunc_q;

endmodule

// File: tb/tb_muu_resp_packetizer512.sv
// Bench for muu_resp_packetizer512: table of single-response vectors,
// hand sequences for truncation, queue-full and mid-packet reset, and a
// randomized run. All output beats are scored against a packet-level model.
`timescale 1ns/1ps
module tb_muu_resp_packetizer512;
  localparam int META_W = 96;
  localparam int MAXW   = 160;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] trunc_count;

  always #5 clk = ~clk;

  muu_resp_packetizer512_if #(.META_WIDTH(META_W)) bus ();

  muu_resp_packetizer512 #(
    .META_WIDTH(META_W), .SESSION_LSB(0), .MAX_WORDS_IN_PACKET(MAXW),
    .BUF_WORDS(256), .LENQ_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .trunc_count(trunc_count)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int tx_mode  = 1;   // 0 low, 1 high, 2 random
  int meta_mode = 1;

  // Reference model: packets built from accepted words by the close rules
  logic [511:0] exp_data[$];
  bit           exp_last[$];
  logic [55:0]  exp_meta[$];
  logic [511:0] cur_words[$];
  logic [15:0]  cur_sess;
  logic [7:0]   cur_user;
  int           exp_trunc = 0;

  // Monitor bookkeeping
  int           meta_count = 0;
  logic [55:0]  last_meta = '0;
  int           last_span = -1;
  int           first_cyc = 0;
  bit           in_pkt = 0;
  bit           stall_pending = 0;
  logic [511:0] stall_data;
  logic         stall_last;
  bit           expect_first = 0;

  function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_accept(logic [511:0] w, logic [15:0] s, logic [7:0] u, bit last);
    int n;
    if (cur_words.size() == 0) begin
      cur_sess = s;
      cur_user = u;
    end
    cur_words.push_back(w);
    n = cur_words.size();
    if (last || n == MAXW) begin
      exp_meta.push_back({cur_user, 32'(n * 64), cur_sess});
      for (int i = 0; i < n; i++) begin
        exp_data.push_back(cur_words[i]);
        exp_last.push_back(i == n - 1);
      end
      if (!last) exp_trunc++;
      cur_words.delete();
    end
  endfunction

  function automatic void model_reset();
    exp_data.delete();
    exp_last.delete();
    exp_meta.delete();
    cur_words.delete();
    exp_trunc = 0;
  endfunction

  // Present one word; called and returns at a falling edge
  task automatic send_word(input logic [511:0] w, input logic [15:0] s,
                           input logic [7:0] u, input bit last);
    int guard = 0;
    bus.in_data  = {$urandom, $urandom, 16'($urandom), s, w};
    bus.in_user  = u;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_accept_timeout: got in_ready=0 required acceptance within 3000 cycles");
    end else begin
      model_accept(w, s, u, last);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_packet(input int n, input logic [15:0] s, input logic [7:0] u, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_word(rand512(), s + 16'(i), u + 8'(i), i == n - 1);
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_meta.size() != 0 || exp_data.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_pending_beats", 512'(exp_meta.size() + exp_data.size()), 512'(0));
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream ready drivers, changed just after the rising edge
  initial begin
    bus.tx_ready      = 1'b0;
    bus.tx_meta_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready      = (tx_mode == 1)   || (tx_mode == 2   && $urandom_range(0, 1) == 1);
      bus.tx_meta_ready = (meta_mode == 1) || (meta_mode == 2 && $urandom_range(0, 1) == 1);
    end
  end

  // Output monitor / scoreboard, sampling on the falling edge
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stall_pending = 0;
      expect_first  = 0;
      in_pkt        = 0;
    end else begin
      if (stall_pending) begin
        chk("hold_valid", 512'(bus.tx_valid), 512'(1));
        chk("hold_data", bus.tx_data, stall_data);
        chk("hold_last", 512'(bus.tx_last), 512'(stall_last));
      end
      if (expect_first) begin
        chk("first_beat_valid", 512'(bus.tx_valid), 512'(1));
        chk("meta_valid_drop", 512'(bus.tx_meta_valid), 512'(0));
        expect_first = 0;
      end
      if (bus.tx_meta_valid && bus.tx_meta_ready) begin
        meta_count++;
        last_meta = bus.tx_meta_data;
        if (exp_meta.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_meta_unexpected: got %0h required no beat", bus.tx_meta_data);
        end else begin
          chk("tx_meta", 512'(bus.tx_meta_data), 512'(exp_meta.pop_front()));
        end
        expect_first = 1;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        chk("tx_keep", 512'(bus.tx_keep), 512'({64{1'b1}}));
        if (exp_data.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_data_unexpected: got %0h required no beat", bus.tx_data);
        end else begin
          chk("tx_data", bus.tx_data, exp_data.pop_front());
          chk("tx_last", 512'(bus.tx_last), 512'(exp_last.pop_front()));
        end
        if (!in_pkt) begin
          in_pkt    = 1;
          first_cyc = cyc;
        end
        if (bus.tx_last) begin
          in_pkt    = 0;
          last_span = cyc - first_cyc;
        end
      end
      stall_pending = bus.tx_valid && !bus.tx_ready;
      stall_data    = bus.tx_data;
      stall_last    = bus.tx_last;
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int          n;
    logic [15:0] sess;
    logic [7:0]  user;
    logic [55:0] exp_meta;
    int          exp_trunc;
    int          exp_span;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base_meta;
    logic [511:0] w6;

    // Single responses; meta on word i carries session+i and user+i, so a
    // forced close shows whether fresh meta was latched for the next packet.
    vecs[0] = '{1,   16'h0012, 8'h03, {8'h03, 32'd64,    16'h0012}, 0, 0};
    vecs[1] = '{5,   16'hBEEF, 8'h7A, {8'h7A, 32'd320,   16'hBEEF}, 0, 4};
    vecs[2] = '{2,   16'h1234, 8'h01, {8'h01, 32'd128,   16'h1234}, 0, 1};
    vecs[3] = '{160, 16'h00FF, 8'h55, {8'h55, 32'd10240, 16'h00FF}, 0, 159};
    vecs[4] = '{161, 16'hA5A5, 8'h09, {8'hA9, 32'd64,    16'hA645}, 1, 0};

    bus.in_data  = '0;
    bus.in_user  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 512'(bus.in_ready), 512'(0));
    chk("rst_meta_valid", 512'(bus.tx_meta_valid), 512'(0));
    chk("rst_tx_valid", 512'(bus.tx_valid), 512'(0));
    chk("rst_tx_last", 512'(bus.tx_last), 512'(0));
    chk("rst_meta_data", 512'(bus.tx_meta_data), 512'(0));
    chk("rst_tx_data", bus.tx_data, 512'(0));
    chk("rst_trunc", 512'(trunc_count), 512'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 512'(bus.in_ready), 512'(1));

    // Table-driven single responses with both readies high
    tx_mode   = 1;
    meta_mode = 1;
    @(negedge clk);
    for (int v = 0; v < 5; v++) begin
      send_packet(vecs[v].n, vecs[v].sess, vecs[v].user, 1'b0);
      wait_drain(2000);
      chk($sformatf("vec%0d_meta", v), 512'(last_meta), 512'(vecs[v].exp_meta));
      chk($sformatf("vec%0d_trunc", v), 512'(trunc_count), 512'(vecs[v].exp_trunc));
      chk($sformatf("vec%0d_span", v), 512'(last_span), 512'(vecs[v].exp_span));
    end

    // 400-word stream closed only by in_last on the final word: 160/160/80
    tx_mode   = 2;
    meta_mode = 2;
    base_meta = meta_count;
    send_packet(400, 16'h4000, 8'h40, 1'b1);
    wait_drain(5000);
    chk("long_trunc", 512'(trunc_count), 512'(3));
    chk("long_trunc_model", 512'(trunc_count), 512'(exp_trunc));
    chk("long_packets", 512'(meta_count - base_meta), 512'(3));
    chk("long_last_meta", 512'(last_meta), 512'({8'h40 + 8'd64, 32'd5120, 16'h4000 + 16'd320}));

    // Length queue full: metadata blocked, five 1-word packets fill the queue
    tx_mode   = 1;
    meta_mode = 0;
    base_meta = meta_count;
    repeat (3) @(negedge clk);
    for (int p = 0; p < 5; p++) send_packet(1, 16'h5000 + 16'(p), 8'(p), 1'b0);
    w6 = rand512();
    bus.in_data  = {96'h0, w6};
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("qfull_in_ready", 512'(bus.in_ready), 512'(0));
      @(negedge clk);
    end
    meta_mode = 1;
    send_word(w6, 16'h5005, 8'h05, 1'b1);
    wait_drain(500);
    chk("qfull_packets", 512'(meta_count - base_meta), 512'(6));
    chk("qfull_last_meta", 512'(last_meta), 512'({8'h05, 32'd64, 16'h5005}));

    // Randomized lengths, readies and input gaps
    tx_mode   = 2;
    meta_mode = 2;
    base_meta = meta_count;
    for (int p = 0; p < 50; p++) begin
      send_packet($urandom_range(1, MAXW), 16'($urandom), 8'($urandom), 1'b1);
    end
    wait_drain(40000);
    chk("rand_packets", 512'(meta_count - base_meta), 512'(50));
    chk("rand_trunc", 512'(trunc_count), 512'(exp_trunc));

    // Reset mid-packet with a word stalled on the output
    tx_mode   = 0;
    meta_mode = 1;
    send_packet(3, 16'h3333, 8'h33, 1'b0);
    for (int k = 0; k < 50 && !bus.tx_valid; k++) @(negedge clk);
    chk("pre_rst_tx_valid", 512'(bus.tx_valid), 512'(1));
    send_word(rand512(), 16'h7000, 8'h70, 1'b0);
    send_word(rand512(), 16'h7001, 8'h71, 1'b0);
    bus.in_data  = {96'h0, rand512()};
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    chk("mid_rst_tx_valid", 512'(bus.tx_valid), 512'(0));
    chk("mid_rst_meta_valid", 512'(bus.tx_meta_valid), 512'(0));
    chk("mid_rst_tx_last", 512'(bus.tx_last), 512'(0));
    chk("mid_rst_in_ready", 512'(bus.in_ready), 512'(0));
    chk("mid_rst_trunc", 512'(trunc_count), 512'(0));
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tx_mode = 1;
    repeat (4) @(negedge clk);
    chk("post_rst_idle_meta", 512'(bus.tx_meta_valid), 512'(0));
    chk("post_rst_idle_tx", 512'(bus.tx_valid), 512'(0));
    send_packet(2, 16'h2222, 8'h22, 1'b0);
    wait_drain(200);
    chk("post_rst_meta", 512'(last_meta), 512'({8'h22, 32'd128, 16'h2222}));
    chk("post_rst_span", 512'(last_span), 512'(1));

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
